pipe_param: RTL and testbench

PIPE_PARAM -- requirements
Module: pipe_param

---
 rtl/pipe_param_if.sv | 38 +++
 rtl/pipe_param.sv | 181 ++++++++++++++++++
 tb/tb_pipe_param.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_param_if.sv
// Instruction/result bundle for pipe_param: the issuing side drives the
// instruction fields and debug addresses, the pipeline returns results.
interface pipe_param_if #(
  parameter  int DW   = 16,
  parameter  int NREG = 16,
  parameter  int AW   = 8,
  localparam int RW   = $clog2(NREG)
) ();
  logic          in_valid;
  logic [RW-1:0] rs1;
  logic [RW-1:0] rs2;
  logic [RW-1:0] rd;
  logic [2:0]    func;
  logic          use_imm;
  logic [DW-1:0] imm;
  logic          wb_en;
  logic          mem_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] z;
  logic          z_valid;
  logic          z_zero;
  logic [RW-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] dbg_maddr;
  logic [DW-1:0] dbg_mdata;

  modport master (
    output in_valid, rs1, rs2, rd, func, use_imm, imm, wb_en, mem_en, addr,
    output dbg_raddr, dbg_maddr,
    input  z, z_valid, z_zero, dbg_rdata, dbg_mdata
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, func, use_imm, imm, wb_en, mem_en, addr,
    input  dbg_raddr, dbg_maddr,
    output z, z_valid, z_zero, dbg_rdata, dbg_mdata
  );
endinterface

// File: rtl/pipe_param.sv
// Four-stage ALU pipeline with register bank and data memory.
// S1 captures the instruction and its regbank operands, S2 holds the ALU
// result, S3 writes the regbank and drives z, S4 is the memory write.
// Operands are forwarded from S2 and S3 so back-to-back dependencies
// see sequential-execution results without stalling.
module pipe_param #(
  parameter  int DW   = 16,
  parameter  int NREG = 16,
  parameter  int AW   = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk_1,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [2:0]    func,
  input  logic          use_imm,
  input  logic [DW-1:0] imm,
  input  logic          wb_en,
  input  logic          mem_en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] z,
  output logic          z_valid,
  output logic          z_zero,
  input  logic [RW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata,
  input  logic [AW-1:0] dbg_maddr,
  output logic [DW-1:0] dbg_mdata
);

  localparam int SW = $clog2(DW);

  typedef enum logic [2:0] {
    F_ADD  = 3'b000,
    F_SUB  = 3'b001,
    F_AND  = 3'b010,
    F_XOR  = 3'b011,
    F_OR   = 3'b100,
    F_SLL  = 3'b101,
    F_SRL  = 3'b110,
    F_PASS = 3'b111
  } func_e;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] mem_q  [2**AW];

  // S1: instruction fields plus operand values read from the regbank
  logic          s1_v_q;
  logic [DW-1:0] s1_a_q;
  logic [DW-1:0] s1_b_q;
  logic [RW-1:0] s1_rs1_q;
  logic [RW-1:0] s1_rs2_q;
  logic          s1_imm_q;
  func_e         s1_func_q;
  logic [RW-1:0] s1_rd_q;
  logic          s1_wb_q;
  logic          s1_mem_q;
  logic [AW-1:0] s1_addr_q;

  // S2: ALU result
  logic          s2_v_q;
  logic [DW-1:0] s2_res_q;
  logic [RW-1:0] s2_rd_q;
  logic          s2_wb_q;
  logic          s2_mem_q;
  logic [AW-1:0] s2_addr_q;

  // S3: output result (z_q) and remaining write controls
  logic          s3_v_q;
  logic [DW-1:0] z_q;
  logic          z_zero_q;
  logic [RW-1:0] s3_rd_q;
  logic          s3_wb_q;
  logic          s3_mem_q;
  logic [AW-1:0] s3_addr_q;

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] s2_res_d;
  logic          s4_we;

  // Operand forwarding: nearest producer (S2) beats older one (S3) beats regbank.
  // The S1 regbank read was taken at the capture edge, so the S3 producer's
  // write had not landed yet and must be forwarded explicitly.
  always_comb begin
    op_a = s1_a_q;
    if (s2_v_q && s2_wb_q && (s2_rd_q == s1_rs1_q)) begin
      op_a = s2_res_q;
    end else if (s3_v_q && s3_wb_q && (s3_rd_q == s1_rs1_q)) begin
      op_a = z_q;
    end

    op_b = s1_b_q;
    if (!s1_imm_q) begin
      if (s2_v_q && s2_wb_q && (s2_rd_q == s1_rs2_q)) begin
        op_b = s2_res_q;
      end else if (s3_v_q && s3_wb_q && (s3_rd_q == s1_rs2_q)) begin
        op_b = z_q;
      end
    end
  end

  // ALU, all results modulo 2^DW
  always_comb begin
    s2_res_d = op_b;
    case (s1_func_q)
      F_ADD:   s2_res_d = op_a + op_b;
      F_SUB:   s2_res_d = op_a - op_b;
      F_AND:   s2_res_d = op_a & op_b;
      F_XOR:   s2_res_d = op_a ^ op_b;
      F_OR:    s2_res_d = op_a | op_b;
      F_SLL:   s2_res_d = op_a << op_b[SW-1:0];
      F_SRL:   s2_res_d = op_a >> op_b[SW-1:0];
      default: s2_res_d = op_b;
    endcase
  end

  // Pipeline advance, regbank write from S2 and S3 output registers
  always_ff @(posedge clk_1) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      z_q      <= '0;
      z_zero_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      s1_v_q    <= in_valid;
      s1_a_q    <= regs_q[rs1];
      s1_b_q    <= use_imm ? imm : regs_q[rs2];
      s1_rs1_q  <= rs1;
      s1_rs2_q  <= rs2;
      s1_imm_q  <= use_imm;
      s1_func_q <= func_e'(func);
      s1_rd_q   <= rd;
      s1_wb_q   <= wb_en;
      s1_mem_q  <= mem_en;
      s1_addr_q <= addr;

      s2_v_q    <= s1_v_q;
      s2_res_q  <= s2_res_d;
      s2_rd_q   <= s1_rd_q;
      s2_wb_q   <= s1_wb_q;
      s2_mem_q  <= s1_mem_q;
      s2_addr_q <= s1_addr_q;

      s3_v_q    <= s2_v_q;
      s3_rd_q   <= s2_rd_q;
      s3_wb_q   <= s2_wb_q;
      s3_mem_q  <= s2_mem_q;
      s3_addr_q <= s2_addr_q;
      z_zero_q  <= s2_v_q && (s2_res_q == '0);
      if (s2_v_q) begin
        z_q <= s2_res_q;
      end
      if (s2_v_q && s2_wb_q) begin
        regs_q[s2_rd_q] <= s2_res_q;
      end
    end
  end

  assign s4_we = s3_v_q && s3_mem_q && !rst;

  // S4 memory write; contents survive reset, but no write on a reset edge
  always_ff @(posedge clk_1) begin
    if (s4_we) begin
      mem_q[s3_addr_q] <= z_q;
    end
  end

  assign z         = z_q;
  assign z_valid   = s3_v_q;
  assign z_zero    = z_zero_q;
  assign dbg_rdata = regs_q[dbg_raddr];
  assign dbg_mdata = mem_q[dbg_maddr];

endmodule

// File: tb/tb_pipe_param.sv
// Scoreboard bench for pipe_param: instructions are executed in program
// order on an architectural model; expected z values (with due cycle) and
// memory writes are queued, and a negedge monitor checks every output cycle.
module tb_pipe_param;
  localparam int DW   = 16;
  localparam int NREG = 16;
  localparam int AW   = 8;
  localparam int RW   = 4;

  logic clk_1 = 1'b0;
  logic rst   = 1'b1;

  pipe_param_if #(.DW(DW), .NREG(NREG), .AW(AW)) bus ();

  pipe_param #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk_1    (clk_1),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rd       (bus.rd),
    .func     (bus.func),
    .use_imm  (bus.use_imm),
    .imm      (bus.imm),
    .wb_en    (bus.wb_en),
    .mem_en   (bus.mem_en),
    .addr     (bus.addr),
    .z        (bus.z),
    .z_valid  (bus.z_valid),
    .z_zero   (bus.z_zero),
    .dbg_raddr(bus.dbg_raddr),
    .dbg_rdata(bus.dbg_rdata),
    .dbg_maddr(bus.dbg_maddr),
    .dbg_mdata(bus.dbg_mdata)
  );

  always #5 clk_1 = ~clk_1;

  int unsigned cyc = 0;
  logic rst_at_edge = 1'b0;
  bit   mon_on = 1'b0;

  always @(posedge clk_1) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
    if (rst) mon_on <= 1'b1;
  end

  typedef struct { int unsigned due; logic [DW-1:0] val; } exp_t;
  typedef struct { int unsigned due; logic [AW-1:0] a; logic [DW-1:0] d; } mw_t;

  exp_t zq[$];
  mw_t  mq[$];
  logic [DW-1:0] regs_m [NREG];
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] last_z = '0;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input int f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sh;
    sh = int'(b) % DW;
    case (f)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a ^ b;
      4: return a | b;
      5: return a << sh;
      6: return a >> sh;
      default: return b;
    endcase
  endfunction

  // drive one instruction slot; valid ones are executed on the model in order
  task automatic issue(input bit v, input int r1, input int r2, input int rdi, input int f,
                       input bit ui, input logic [DW-1:0] im, input bit wb, input bit me,
                       input int ad);
    logic [DW-1:0] a, b, res;
    @(negedge clk_1);
    bus.in_valid = v;
    bus.rs1      = RW'(r1);
    bus.rs2      = RW'(r2);
    bus.rd       = RW'(rdi);
    bus.func     = 3'(f);
    bus.use_imm  = ui;
    bus.imm      = im;
    bus.wb_en    = wb;
    bus.mem_en   = me;
    bus.addr     = AW'(ad);
    if (v && !rst) begin
      a   = regs_m[r1];
      b   = ui ? im : regs_m[r2];
      res = ref_alu(f, a, b);
      zq.push_back('{cyc + 3, res});
      if (wb) regs_m[rdi] = res;
      if (me) mq.push_back('{cyc + 4, AW'(ad), res});
    end
  endtask

  task automatic rand_fields(input bit v);
    issue(v, $urandom_range(0, NREG-1), $urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
          $urandom_range(0, 7), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2), $urandom_range(0, 255));
  endtask

  task automatic bubble(input int n);
    repeat (n) rand_fields(1'b0);
  endtask

  // everything not yet visible before the reset edge is discarded
  task automatic do_reset(input int n);
    exp_t ek[$];
    mw_t  mk[$];
    @(negedge clk_1);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    foreach (zq[i]) if (zq[i].due <= cyc) ek.push_back(zq[i]);
    foreach (mq[i]) if (mq[i].due <= cyc) mk.push_back(mq[i]);
    zq = ek;
    mq = mk;
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    for (int i = 1; i < n; i++) begin
      @(negedge clk_1);
      bus.rd  = RW'($urandom);
      bus.imm = DW'($urandom);
    end
    @(negedge clk_1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    mw_t w;
    bubble(5);
    check({tag, "_queue_drained"}, zq.size(), 0);
    while (mq.size() > 0) begin
      w = mq.pop_front();
      mem_m[int'(w.a)] = w.d;
    end
    for (int r = 0; r < NREG; r++) begin
      bus.dbg_raddr = RW'(r);
      #1;
      check($sformatf("%s_reg%0d", tag, r), bus.dbg_rdata, regs_m[r]);
    end
    foreach (mem_m[k]) begin
      bus.dbg_maddr = AW'(k);
      #1;
      check($sformatf("%s_mem%0h", tag, k), bus.dbg_mdata, mem_m[k]);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk_1) begin
    exp_t e;
    if (mon_on) begin
      if (rst_at_edge) begin
        check("reset_z", bus.z, '0);
        check("reset_z_valid", bus.z_valid, 0);
        check("reset_z_zero", bus.z_zero, 0);
        last_z = '0;
      end else if (bus.z_valid) begin
        if (zq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_z: got z=%h with z_valid=1 expected no result (cycle %0d)", bus.z, cyc);
        end else begin
          e = zq.pop_front();
          check("z_latency", cyc, e.due);
          check("z_value", bus.z, e.val);
          check("z_zero", bus.z_zero, (e.val == '0));
          last_z = bus.z;
        end
      end else begin
        check("z_hold", bus.z, last_z);
        check("z_zero_bubble", bus.z_zero, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.func = '0;
    bus.use_imm = 1'b0; bus.imm = '0; bus.wb_en = 1'b0; bus.mem_en = 1'b0; bus.addr = '0;
    bus.dbg_raddr = '0; bus.dbg_maddr = '0;
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    do_reset(2);

    // load, plus old-value-until-after-write on the debug port
    issue(1, 0, 0, 1, 7, 1, 16'h1234, 1, 0, 0);
    bus.dbg_raddr = 4'd1;
    bubble(2);
    check("dbg_old_before_write", bus.dbg_rdata, 16'h0000);
    bubble(1);
    check("dbg_new_after_write", bus.dbg_rdata, 16'h1234);

    // forwarding at distance 1 and 2
    issue(1, 0, 0, 1, 7, 1, 16'd5, 1, 0, 0);
    issue(1, 0, 0, 2, 7, 1, 16'd3, 1, 0, 0);
    issue(1, 1, 2, 3, 0, 0, '0, 1, 0, 0);
    issue(1, 3, 1, 4, 1, 0, '0, 1, 0, 0);
    issue(1, 3, 4, 5, 3, 0, '0, 1, 0, 0);
    check_state("fwd");

    // wrap and shifts
    issue(1, 0, 0, 1, 7, 1, 16'h0000, 1, 0, 0);
    issue(1, 1, 0, 2, 1, 1, 16'd1, 1, 0, 0);
    issue(1, 2, 0, 3, 5, 1, 16'd4, 1, 0, 0);
    issue(1, 3, 0, 4, 6, 1, 16'd15, 1, 0, 0);
    check_state("shift");

    // memory-only write must not forward or touch the regbank
    issue(1, 0, 0, 9, 0, 1, 16'h00AA, 0, 1, 8'h7F);
    issue(1, 9, 9, 10, 0, 0, '0, 1, 0, 0);
    check_state("mem");

    // reset with writes in flight; memory at 0x10..0x12 must keep its values
    issue(1, 0, 0, 0, 7, 1, 16'hC0DE, 0, 1, 8'h10);
    issue(1, 0, 0, 0, 7, 1, 16'hC0DF, 0, 1, 8'h11);
    issue(1, 0, 0, 0, 7, 1, 16'hC0E0, 0, 1, 8'h12);
    check_state("premem");
    issue(1, 0, 0, 6, 7, 1, 16'h1111, 1, 1, 8'h10);
    issue(1, 0, 0, 6, 7, 1, 16'h2222, 1, 1, 8'h11);
    issue(1, 0, 0, 6, 7, 1, 16'h3333, 1, 1, 8'h12);
    do_reset(2);
    issue(1, 6, 6, 7, 0, 0, '0, 1, 0, 0);
    check_state("rstmid");

    // randomized traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 2));
      else rand_fields($urandom_range(0, 9) < 7);
    end
    check_state("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
